stg1fq: RTL and testbench
=========================

// Module: stg1fq
// PURPOSE
//  Instruction fetch queue between stg1if and stg2id. Buffers fetched {pc,instr} pairs so that
//  decode back-pressure does not lose instructions. Valid/ready on both sides; flushed on a
//  front-end redirect (branch/jump/exception). Output is show-ahead: the head entry is always presented.
// PARAMETERS
//  P_DEPTH   4           entry count; power of two, >= 2
//  P_ADDR_W  `SIZE_ADDR  pc width (sizes.vh)
//  P_DATA_W  `SIZE_DATA  instruction width (sizes.vh)
// PORTS
//  iw_clk     in   1                clock, all state on rising edge
//  iw_rst_n   in   1                reset, asynchronous, active-low
//  iw_flush   in   1                redirect: discard all entries
//  iw_valid   in   1                IF presents an entry
//  iw_pc      in   P_ADDR_W         pc of incoming entry
//  iw_instr   in   P_DATA_W         incoming instruction word
//  ow_ready   out  1                queue accepts an entry this cycle
//  ow_valid   out  1                head entry valid toward ID
//  ow_pc      out  P_ADDR_W         head pc
//  ow_instr   out  P_DATA_W         head instruction
//  iw_ready   in   1                ID accepts head this cycle
//  ow_count   out  log2(P_DEPTH)+1  stored entries, 0..P_DEPTH
//  ow_drop    out  1                sticky: entry offered while queue full
// BEHAVIOUR
//  - Reset (iw_rst_n=0, async): rd/wr pointers 0, count 0, ow_valid 0, ow_pc 0, ow_instr 0,
//    ow_drop 0, ow_ready 1. Storage array not reset.
//  - push = iw_valid & ow_ready & ~iw_flush; pop = ow_valid & iw_ready & ~iw_flush.
//  - ow_ready = (count != P_DEPTH). No pass-through when full: a pop does not make room in the same cycle.
//  - push: mem[wr] <= {iw_pc,iw_instr}; wr <= wr+1 (wraps mod P_DEPTH). pop: rd <= rd+1 (wraps).
//  - count: +1 push only, -1 pop only, unchanged on both or neither.
//  - Output: ow_valid = (count != 0); ow_pc/ow_instr = mem[rd] when valid, all-zero when empty.
//  - Latency (macro off): entry pushed at edge N is visible on ow_* after edge N, i.e., 1 cycle.
//  - Order: strict FIFO; a held head (iw_ready=0) keeps ow_* stable until popped or flushed.
//  - Flush: at next edge pointers and count -> 0, ow_valid -> 0, ow_drop -> 0; a push or pop in
//    the flush cycle is ignored. Flush has priority over everything except reset.
//  - ow_drop: set at edge when iw_valid & ~ow_ready & ~iw_flush; holds until flush or reset.
//  - Reset mid-transfer: all entries lost; producer must re-fetch from the reset pc.
//  - Count never exceeds P_DEPTH and never underflows. Simulation assertions check:
//    push while full, and pop while empty.
// CONFIGURATION
//  DIAD_FQ_BYPASS_EN defined: when count==0 and ~iw_flush, the incoming entry drives ow_* combinationally.
//    ow_valid=iw_valid, ow_pc=iw_pc, ow_instr=iw_instr. Zero-cycle latency.
//    If iw_ready is high in that cycle, the entry is consumed and not stored.
//    Pointers and count are unchanged.
//    If iw_ready is low, the entry is stored normally.
//    iw_ready then combinationally gates push in that case; ow_ready is unaffected.
//  Undefined: no combinational path from iw_* to ow_*; 1-cycle latency as above.
// TESTING
//  1 Reset: hold iw_rst_n=0 with iw_valid=1 -> ow_valid=0, ow_count=0, ow_ready=1, ow_drop=0.
//  2 Streaming: push pc 0x10..0x13 (instr 0xA0..0xA3), iw_ready=1 -> ow_* = 0x10/0xA0 one cycle after
//    first push (bypass: same cycle). Output is in order, count stays <=1.
//  3 Fill/back-pressure: iw_ready=0, push 5 entries pc 0..4 -> count=4, ow_ready=0 after 4th.
//    5th offer sets ow_drop=1. Head stays pc 0. Then iw_ready=1 -> pc 0,1,2,3 drain; pc 4 is absent.
//  4 Full with simultaneous pop and offer: count=4, iw_valid=1, iw_ready=1 -> count=3.
//    The offered entry is not stored; the next cycle's offer is accepted.
//  5 Flush: count=3, assert iw_flush with iw_valid=1 -> next cycle count=0, ow_valid=0, ow_drop=0.
//    The flush-cycle entry is not stored; the next push appears as head.
//  6 Wrap: P_DEPTH=4, run 10 push/pop pairs pc 0..9 with iw_ready toggling 1,0 ->
//    all pcs are seen once, in order, across pointer wrap.

Source files
------------

// File: rtl/stg1fq_if.sv
// Fetch-queue port bundle: IF-side push, ID-side show-ahead head, status.
// master drives the iw_* side (fetch + decode), slave is the queue itself.
interface stg1fq_if #(
  parameter int P_DEPTH  = 4,
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32
);
  localparam int CNT_W = $clog2(P_DEPTH) + 1;

  logic                iw_flush;
  logic                iw_valid;
  logic [P_ADDR_W-1:0] iw_pc;
  logic [P_DATA_W-1:0] iw_instr;
  logic                ow_ready;
  logic                ow_valid;
  logic [P_ADDR_W-1:0] ow_pc;
  logic [P_DATA_W-1:0] ow_instr;
  logic                iw_ready;
  logic [CNT_W-1:0]    ow_count;
  logic                ow_drop;

  modport master (
    output iw_flush, iw_valid, iw_pc, iw_instr, iw_ready,
    input  ow_ready, ow_valid, ow_pc, ow_instr, ow_count, ow_drop
  );

  modport slave (
    input  iw_flush, iw_valid, iw_pc, iw_instr, iw_ready,
    output ow_ready, ow_valid, ow_pc, ow_instr, ow_count, ow_drop
  );
endinterface

// File: rtl/stg1fq.sv
// Show-ahead {pc,instr} fetch queue, 1-cycle latency, full => ow_ready low (no pass-through), flush clears.
// DIAD_FQ_BYPASS_EN: empty queue forwards the incoming entry to ID combinationally.
module stg1fq #(
  parameter int P_DEPTH  = 4,
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32
) (
  input  logic     iw_clk,
  input  logic     iw_rst_n,
  stg1fq_if.slave  fq
);
  localparam int PTR_W = $clog2(P_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [P_ADDR_W-1:0] pc;
    logic [P_DATA_W-1:0] instr;
  } fq_ent_t;

  fq_ent_t          mem [P_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             drop;
  logic             not_full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic             head_vld;
  fq_ent_t          head;

  assign not_full  = (count != CNT_W'(P_DEPTH));
  assign not_empty = (count != '0);

  always_comb begin
    push     = fq.iw_valid & not_full & ~fq.iw_flush;
    pop      = not_empty & fq.iw_ready & ~fq.iw_flush;
    head_vld = not_empty;
    head     = not_empty ? mem[rd_ptr] : '0;
`ifdef DIAD_FQ_BYPASS_EN
    // Empty queue: ID sees the incoming entry now; store it only if ID stalls.
    if (!not_empty && !fq.iw_flush) begin
      head_vld = fq.iw_valid;
      head     = '{pc: fq.iw_pc, instr: fq.iw_instr};
      push     = fq.iw_valid & ~fq.iw_ready;
    end
`endif
  end

  assign fq.ow_ready = not_full;
  assign fq.ow_valid = head_vld;
  assign fq.ow_pc    = head.pc;
  assign fq.ow_instr = head.instr;
  assign fq.ow_count = count;
  assign fq.ow_drop  = drop;

  always_ff @(posedge iw_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: fq.iw_pc, instr: fq.iw_instr};
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else if (fq.iw_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (fq.iw_valid && !not_full) drop <= 1'b1;
    end
  end

  a_no_push_full: assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
    !(push && count == CNT_W'(P_DEPTH)));
  a_no_pop_empty: assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
    !(pop && count == '0));
  a_count_bound:  assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
    count <= CNT_W'(P_DEPTH));
endmodule

// File: tb/tb_stg1fq.sv
// Bench for stg1fq (default build): vector table for fill/flush corners, scoreboard for streaming/wrap.
module tb_stg1fq;
  localparam int DEPTH = 4;

  logic iw_clk;
  logic iw_rst_n;
  int   errs;
  int   checks;

  stg1fq_if #(.P_DEPTH(DEPTH), .P_ADDR_W(32), .P_DATA_W(32)) fq ();

  stg1fq #(.P_DEPTH(DEPTH), .P_ADDR_W(32), .P_DATA_W(32)) dut (
    .iw_clk   (iw_clk),
    .iw_rst_n (iw_rst_n),
    .fq       (fq.slave)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [2:0]  e_count;
    logic        e_ready;
    logic        e_drop;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t sb_q[$];
  vec_t vt[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One scoreboard cycle: drive at negedge, check against model, update model for the coming edge.
  task automatic sb_cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                          input logic rdy, output logic acc, output logic popped);
    ent_t e;
    @(negedge iw_clk);
    fq.iw_flush = 1'b0;
    fq.iw_valid = v;
    fq.iw_pc    = pc;
    fq.iw_instr = ins;
    fq.iw_ready = rdy;
    #1;
    acc    = v && (sb_q.size() != DEPTH);
    popped = 1'b0;
    chk("sb_valid", 64'(fq.ow_valid), 64'(sb_q.size() != 0));
    chk("sb_count", 64'(fq.ow_count), 64'(sb_q.size()));
    chk("sb_ready", 64'(fq.ow_ready), 64'(sb_q.size() != DEPTH));
    if (sb_q.size() != 0 && rdy) begin
      e = sb_q.pop_front();
      chk("sb_pc", 64'(fq.ow_pc), 64'(e.pc));
      chk("sb_instr", 64'(fq.ow_instr), 64'(e.instr));
      popped = 1'b1;
    end
    if (acc) sb_q.push_back('{pc: pc, instr: ins});
  endtask

  initial begin
    logic acc;
    logic popped;
    int   pc_next;
    int   seen;
    errs   = 0;
    checks = 0;

    vt[0]  = '{1'b0, 1'b1, 32'd0, 32'hB0, 1'b0, 1'b1, 32'd0, 32'hB0, 3'd1, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 32'd1, 32'hB1, 1'b0, 1'b1, 32'd0, 32'hB0, 3'd2, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'd2, 32'hB2, 1'b0, 1'b1, 32'd0, 32'hB0, 3'd3, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'd3, 32'hB3, 1'b0, 1'b1, 32'd0, 32'hB0, 3'd4, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'd4, 32'hB4, 1'b0, 1'b1, 32'd0, 32'hB0, 3'd4, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 32'd5, 32'hB5, 1'b1, 1'b1, 32'd1, 32'hB1, 3'd3, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 32'd6, 32'hB6, 1'b0, 1'b1, 32'd1, 32'hB1, 3'd4, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 32'd0, 32'h00, 1'b1, 1'b1, 32'd2, 32'hB2, 3'd3, 1'b1, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 32'd7, 32'hB7, 1'b1, 1'b0, 32'd0, 32'h00, 3'd0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 32'd8, 32'hB8, 1'b0, 1'b1, 32'd8, 32'hB8, 3'd1, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 32'd9, 32'hB9, 1'b1, 1'b1, 32'd9, 32'hB9, 3'd1, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 32'd0, 32'h00, 1'b1, 1'b0, 32'd0, 32'h00, 3'd0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 32'd0, 32'h00, 1'b1, 1'b0, 32'd0, 32'h00, 3'd0, 1'b1, 1'b0};

    // Reset held with an offer present
    iw_rst_n    = 1'b0;
    fq.iw_flush = 1'b0;
    fq.iw_valid = 1'b1;
    fq.iw_pc    = 32'h99;
    fq.iw_instr = 32'h99;
    fq.iw_ready = 1'b0;
    repeat (2) @(posedge iw_clk);
    @(negedge iw_clk);
    chk("rst_valid", 64'(fq.ow_valid), 64'd0);
    chk("rst_count", 64'(fq.ow_count), 64'd0);
    chk("rst_ready", 64'(fq.ow_ready), 64'd1);
    chk("rst_drop",  64'(fq.ow_drop),  64'd0);
    chk("rst_pc",    64'(fq.ow_pc),    64'd0);
    fq.iw_valid = 1'b0;
    iw_rst_n    = 1'b1;

    // Streaming with ID always ready
    for (int i = 0; i < 4; i++) begin
      sb_cycle(1'b1, 32'h10 + 32'(i), 32'hA0 + 32'(i), 1'b1, acc, popped);
      chk("stream_acc", 64'(acc), 64'd1);
    end
    for (int i = 0; i < 3; i++) sb_cycle(1'b0, 32'h0, 32'h0, 1'b1, acc, popped);

    // Fill / drop / full pop+offer / flush corners
    for (int i = 0; i < 13; i++) begin
      @(negedge iw_clk);
      fq.iw_flush = vt[i].flush;
      fq.iw_valid = vt[i].valid;
      fq.iw_pc    = vt[i].pc;
      fq.iw_instr = vt[i].instr;
      fq.iw_ready = vt[i].ready;
      @(posedge iw_clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(fq.ow_valid), 64'(vt[i].e_valid));
      chk($sformatf("vec%0d_pc",    i), 64'(fq.ow_pc),    64'(vt[i].e_pc));
      chk($sformatf("vec%0d_instr", i), 64'(fq.ow_instr), 64'(vt[i].e_instr));
      chk($sformatf("vec%0d_count", i), 64'(fq.ow_count), 64'(vt[i].e_count));
      chk($sformatf("vec%0d_ready", i), 64'(fq.ow_ready), 64'(vt[i].e_ready));
      chk($sformatf("vec%0d_drop",  i), 64'(fq.ow_drop),  64'(vt[i].e_drop));
    end

    // Wrap: 10 entries, ID ready toggling 1,0
    pc_next = 0;
    seen    = 0;
    for (int cyc = 0; cyc < 200 && seen < 10; cyc++) begin
      sb_cycle(pc_next < 10, 32'(pc_next), 32'hC0 + 32'(pc_next), (cyc % 2) == 0, acc, popped);
      if (acc) pc_next++;
      if (popped) seen++;
    end
    chk("wrap_seen", 64'(seen), 64'd10);

    // Asynchronous reset mid-transfer
    sb_cycle(1'b1, 32'h50, 32'hD0, 1'b0, acc, popped);
    sb_cycle(1'b1, 32'h51, 32'hD1, 1'b0, acc, popped);
    sb_cycle(1'b0, 32'h0, 32'h0, 1'b0, acc, popped);
    #1;
    iw_rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(fq.ow_valid), 64'd0);
    chk("arst_count", 64'(fq.ow_count), 64'd0);
    chk("arst_pc",    64'(fq.ow_pc),    64'd0);
    sb_q.delete();
    @(negedge iw_clk);
    iw_rst_n = 1'b1;
    sb_cycle(1'b1, 32'h60, 32'hE0, 1'b0, acc, popped);
    sb_cycle(1'b0, 32'h0, 32'h0, 1'b1, acc, popped);
    sb_cycle(1'b0, 32'h0, 32'h0, 1'b1, acc, popped);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
